// File: rtl/bram_loader_pkg.sv
// Shared parsing-stage definitions: BRAM geometry, loader FSM encoding and
// the request-size rule used by the loader.
package bram_loader_pkg;

  localparam int DW   = 128;  // BRAM word width
  localparam int AW   = 9;    // BRAM address width (512 deep)
  localparam int NB   = 16;   // number of BRAM banks
  localparam int CNTW = 14;   // beat-count width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } loaderStateT;

  // A load request is legal when it asks for at least one beat and no more
  // beats than the bank array can hold.
  function automatic logic countInRange(input logic [CNTW-1:0] n, input int maxWords);
    return (n != '0) && (int'({1'b0, n}) <= maxWords);
  endfunction

endpackage

// File: rtl/bram_loader.sv
// Streams a counted burst of beats round-robin into a BRAM bank array, then
// pulses o_start to the downstream parser once the last word has landed.
module bram_loader
  import bram_loader_pkg::*;
#(
  parameter int DW = bram_loader_pkg::DW,
  parameter int AW = bram_loader_pkg::AW,
  parameter int NB = bram_loader_pkg::NB
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_load_start,
  input  logic [CNTW-1:0] i_num_words,
  input  logic            i_abort,
  input  logic            i_valid,
  input  logic [DW-1:0]   i_data,
  output logic            o_ready,
  output logic [NB-1:0]   o_ena,
  output logic [NB-1:0]   o_wea,
  output logic [AW-1:0]   o_addra,
  output logic [DW-1:0]   o_dia,
  output logic            o_start,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);

  localparam int MAX_WORDS = NB * (2 ** AW);
  localparam int BW        = (NB > 1) ? $clog2(NB) : 1;

  loaderStateT     state, stateNext;
  logic [CNTW-1:0] numWords;
  logic [CNTW-1:0] beatCnt;
  logic [BW-1:0]   bankIdx;
  logic [AW-1:0]   addr;
  logic [NB-1:0]   wrStrobe;
  logic [AW-1:0]   wrAddr;
  logic [DW-1:0]   wrData;
  logic            errPulse;
  logic            startOk;
  logic            startReq;
  logic            accept;
  logic            lastBeat;

  assign startOk  = countInRange(i_num_words, MAX_WORDS);
  assign startReq = (state == IDLE) && i_load_start;
  // Abort wins over a beat offered in the same cycle: that beat is dropped.
  assign accept   = (state == LOAD) && i_valid && !i_abort;
  assign lastBeat = (beatCnt == numWords - CNTW'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the values from before the edge, independent of block order.
      state <= stateNext;
    end
  end

  always_comb begin
    // NOTE: default assigned first so every path drives stateNext; a missing
    // branch would otherwise infer a latch.
    stateNext = state;
    unique case (state)
      IDLE:    if (startReq && startOk) stateNext = LOAD;
      LOAD: begin
        if (i_abort)                stateNext = IDLE;
        else if (accept && lastBeat) stateNext = FLUSH;
      end
      FLUSH:   stateNext = i_abort ? IDLE : DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the write address/data registers are reset as well so the bank
      // ports never present X, even though strobes are what qualify a write.
      numWords <= '0;
      beatCnt  <= '0;
      bankIdx  <= '0;
      addr     <= '0;
      wrStrobe <= '0;
      wrAddr   <= '0;
      wrData   <= '0;
      errPulse <= 1'b0;
    end else begin
      wrStrobe <= '0;
      errPulse <= startReq && !startOk;

      if (startReq && startOk) begin
        numWords <= i_num_words;
        beatCnt  <= '0;
        bankIdx  <= '0;
        addr     <= '0;
      end

      if (accept) begin
        wrStrobe <= NB'(1) << bankIdx;
        wrAddr   <= addr;
        wrData   <= i_data;
        beatCnt  <= beatCnt + CNTW'(1);
        // Banks fill round-robin; the row address advances after the last bank.
        if (bankIdx == BW'(NB - 1)) begin
          bankIdx <= '0;
          addr    <= addr + AW'(1);
        end else begin
          bankIdx <= bankIdx + BW'(1);
        end
      end
    end
  end

  assign o_ready = (state == LOAD);
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);
  assign o_start = (state == DONE);
  assign o_err   = errPulse;
  assign o_ena   = wrStrobe;
  assign o_wea   = wrStrobe;
  assign o_addra = wrAddr;
  assign o_dia   = wrData;

endmodule

// File: tb/tb_bram_loader.sv
// Self-checking bench for bram_loader: table of load requests driven with
// random flow control, checked against a beat-index model of the bank array.
module tb_bram_loader;
  import bram_loader_pkg::*;

  logic            clk = 1'b0;
  logic            rstn;
  logic            i_load_start;
  logic [CNTW-1:0] i_num_words;
  logic            i_abort;
  logic            i_valid;
  logic [DW-1:0]   i_data;
  logic            o_ready;
  logic [NB-1:0]   o_ena;
  logic [NB-1:0]   o_wea;
  logic [AW-1:0]   o_addra;
  logic [DW-1:0]   o_dia;
  logic            o_start;
  logic            o_busy;
  logic            o_done;
  logic            o_err;

  bram_loader #(.DW(DW), .AW(AW), .NB(NB)) dut (
    .clk(clk), .rstn(rstn),
    .i_load_start(i_load_start), .i_num_words(i_num_words),
    .i_abort(i_abort), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_ena(o_ena), .o_wea(o_wea),
    .o_addra(o_addra), .o_dia(o_dia), .o_start(o_start),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- write monitor ----------------
  typedef struct {
    int            bank;
    int            addr;
    logic [DW-1:0] data;
    int            cyc;
  } wrRecT;

  wrRecT writeQ[$];
  int    coverCnt[NB][2**AW];
  int    startCnt, doneCnt, errCnt, badStrobe, busySeen, startCyc;

  task automatic clearMon();
    writeQ.delete();
    startCnt = 0; doneCnt = 0; errCnt = 0;
    badStrobe = 0; busySeen = 0; startCyc = -1;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 2**AW; a++) coverCnt[b][a] = 0;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (o_busy) busySeen++;
      if (o_ena != '0 || o_wea != '0) begin
        int b;
        b = -1;
        if (o_ena != o_wea || $countones(o_ena) != 1) badStrobe++;
        for (int i = 0; i < NB; i++) if (o_ena[i]) b = i;
        writeQ.push_back('{b, int'(o_addra), o_dia, cyc});
        if (b >= 0) coverCnt[b][o_addra]++;
      end
      if (o_start) begin startCnt++; startCyc = cyc; end
      if (o_done) doneCnt++;
      if (o_err)  errCnt++;
    end
  end

  task automatic checkZero(input string tag);
    check({tag, "_ctl"},  {o_ready, o_start, o_done, o_err, o_busy}, 0);
    check({tag, "_ena"},  {o_ena, o_wea}, 0);
    check({tag, "_addr"}, o_addra, 0);
    check({tag, "_dia"},  o_dia, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int numWords;
    int validPct;
    bit indexData;
    int abortAfter;   // -1: no abort
    bit midStart;     // pulse i_load_start mid-load (must be ignored)
    bit expErr;
    int expWrites;
    bit expDone;
  } vecT;

  vecT vecs[$];

  task automatic runVec(input vecT v, input int idx);
    logic [DW-1:0] sentData[$];
    logic [DW-1:0] d;
    int            sent, budget, lastAcc, mism;
    logic          acc;
    string         tag;
    tag = $sformatf("v%0d_n%0d", idx, v.numWords);
    clearMon();
    @(posedge clk); #1;
    i_load_start = 1'b1;
    i_num_words  = CNTW'(v.numWords);
    @(posedge clk); #1;
    i_load_start = 1'b0;
    sent = 0;
    lastAcc = -1;
    if (!v.expErr) begin
      budget = v.numWords * 20 + 100;
      while (sent < v.numWords && budget > 0) begin
        if (sent == v.abortAfter) begin
          i_valid = 1'b0;
          i_abort = 1'b1;
          @(posedge clk); #1;
          i_abort = 1'b0;
          break;
        end
        i_valid = ($urandom_range(99) < v.validPct);
        d = v.indexData ? DW'(sent) : {$urandom, $urandom, $urandom, $urandom};
        i_data = d;
        if (v.midStart && sent == v.numWords / 2) begin
          i_load_start = 1'b1;
          i_num_words  = CNTW'(3);
        end
        @(negedge clk);
        acc = i_valid && o_ready;
        if (acc) begin
          sentData.push_back(d);
          lastAcc = cyc;
        end
        @(posedge clk); #1;
        i_load_start = 1'b0;
        if (acc) sent++;
        budget--;
      end
      i_valid = 1'b0;
      check({tag, "_accepts"}, sent, v.expWrites);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);

    // Reference: beat k lands in bank k mod NB at row k / NB.
    mism = 0;
    foreach (writeQ[k]) begin
      if (k >= sentData.size()) mism++;
      else if (writeQ[k].bank != k % NB || writeQ[k].addr != k / NB ||
               writeQ[k].data !== sentData[k]) mism++;
    end
    check({tag, "_err"},     errCnt, v.expErr);
    check({tag, "_nwrites"}, writeQ.size(), v.expWrites);
    check({tag, "_content"}, mism, 0);
    check({tag, "_strobe"},  badStrobe, 0);
    check({tag, "_done"},    doneCnt, v.expDone);
    check({tag, "_start"},   startCnt, v.expDone);
    check({tag, "_idle"},    o_busy, 0);
    if (v.expDone) begin
      check({tag, "_startLat"}, startCyc, lastAcc + 2);
      check({tag, "_lastWrCyc"}, (writeQ.size() > 0) ? writeQ[$].cyc : -1, lastAcc + 1);
    end
    if (v.expErr) check({tag, "_busySeen"}, busySeen, 0);
    if (v.numWords == 17) begin
      check({tag, "_lastBank"}, (writeQ.size() > 0) ? writeQ[$].bank : -1, 0);
      check({tag, "_lastAddr"}, (writeQ.size() > 0) ? writeQ[$].addr : -1, 1);
    end
    if (v.numWords == NB * (2**AW)) begin
      mism = 0;
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < 2**AW; a++) if (coverCnt[b][a] != 1) mism++;
      check({tag, "_cover"}, mism, 0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    rstn = 1'b0; i_load_start = 1'b0; i_num_words = '0;
    i_abort = 1'b0; i_valid = 1'b0; i_data = '0;
    clearMon();
    #12;
    checkZero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    //                  n  vld idx abort mid err writes done
    vecs.push_back('{  32, 100, 1,  -1,  0,  0,   32,  1});
    vecs.push_back('{  17, 100, 0,  -1,  0,  0,   17,  1});
    vecs.push_back('{   0, 100, 0,  -1,  0,  1,    0,  0});
    vecs.push_back('{9000, 100, 0,  -1,  0,  1,    0,  0});
    vecs.push_back('{  20,  70, 0,   5,  0,  0,    5,  0});
    vecs.push_back('{  20, 100, 0,  -1,  0,  0,   20,  1});
    vecs.push_back('{   1, 100, 0,  -1,  0,  0,    1,  1});
    vecs.push_back('{8193, 100, 0,  -1,  0,  1,    0,  0});
    vecs.push_back('{  16,  50, 0,  -1,  1,  0,   16,  1});
    vecs.push_back('{  50,  30, 0,  -1,  0,  0,   50,  1});
    vecs.push_back('{8192,  60, 0,  -1,  0,  0, 8192,  1});

    foreach (vecs[i]) runVec(vecs[i], i);

    // Stall then reset after 10 accepts of a 20-word load.
    clearMon();
    @(posedge clk); #1;
    i_load_start = 1'b1; i_num_words = CNTW'(20);
    @(posedge clk); #1;
    i_load_start = 1'b0;
    @(negedge clk);
    check("stall_ready", o_ready, 1);
    check("stall_busy",  o_busy, 1);
    check("stall_nowr",  o_ena, 0);
    @(posedge clk); #1;
    sent = 0;
    for (int c = 0; c < 100 && sent < 10; c++) begin
      i_valid = 1'b1;
      i_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (o_ready) sent++;
      @(posedge clk); #1;
    end
    check("midrst_accepts", sent, 10);
    #1;
    rstn = 1'b0;
    #1;
    checkZero("midrst");
    @(posedge clk); #1;
    rstn = 1'b1;
    clearMon();
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("postrst_writes", writeQ.size(), 0);
    check("postrst_busy",   busySeen, 0);
    check("postrst_start",  startCnt, 0);
    i_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/bram_loader.md
BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 SHALL have parameter DW, default 128, BRAM word width.
REQ-002 SHALL have parameter AW, default 9, BRAM address width (depth 2**AW = 512).
REQ-003 SHALL have parameter NB, default 16, number of BRAM banks.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_load_start  input  1  one-cycle request to begin a load.
REQ-007 SHALL have port i_num_words  input  14  total beats to load; sampled with i_load_start.
REQ-008 SHALL have port i_abort  input  1  synchronous abort of the current load.
REQ-009 SHALL have port i_valid  input  1  input stream beat valid.
REQ-010 SHALL have port i_data  input  DW  input stream beat.
REQ-011 SHALL have port o_ready  output  1  beat accepted when i_valid && o_ready.
REQ-012 SHALL have ports o_ena and o_wea  output  NB  per-bank write enable and write strobe to the BRAM bank array.
REQ-013 SHALL have port o_addra  output  AW  shared write address.
REQ-014 SHALL have port o_dia  output  DW  shared write data.
REQ-015 SHALL have port o_start  output  1  one-cycle start pulse to the downstream parsing stage (iStart).
REQ-016 SHALL have ports o_busy, o_done and o_err  output  1 each  load in progress, load-complete pulse, and bad-request pulse.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, FLUSH and DONE.
REQ-018 In IDLE, i_load_start with 1 <= i_num_words <= NB*2**AW SHALL latch the count, clear bank index and address, and enter LOAD.
REQ-019 In IDLE, i_load_start with i_num_words == 0 or > 8192 SHALL pulse o_err for one cycle and remain in IDLE.
REQ-020 i_load_start outside IDLE SHALL be ignored.
REQ-021 o_ready SHALL equal (state == LOAD); it is combinational from state only, never from i_valid.
REQ-022 Beat k (0-based) SHALL be written to bank k mod NB at address k / NB, so banks fill round-robin and the address increments after bank NB-1.
REQ-023 Write latency SHALL be one cycle: the cycle after acceptance, o_ena[b] = o_wea[b] = 1 for that bank only, with o_addra and o_dia registered.
REQ-024 In any cycle with no write pending, o_ena and o_wea SHALL be all-zero; o_addra and o_dia hold their previous values.
REQ-025 i_valid low in LOAD SHALL stall the load with no write and no state change; back-to-back beats SHALL sustain one write per cycle.
REQ-026 Acceptance of the final beat SHALL move the FSM LOAD -> FLUSH; the final write strobe occurs in FLUSH.
REQ-027 FLUSH SHALL go to DONE; DONE SHALL assert o_done and o_start for exactly one cycle, then return to IDLE.
REQ-028 o_start therefore SHALL rise two cycles after the final beat is accepted, strictly after the last BRAM write.
REQ-029 o_busy SHALL equal (state != IDLE).
REQ-030 i_abort in LOAD or FLUSH SHALL return the FSM to IDLE next cycle; any write already registered still completes, no further writes occur, and o_done and o_start are not pulsed.
REQ-031 i_abort in IDLE or DONE SHALL be ignored.
REQ-032 Beat counter arithmetic SHALL be 14-bit unsigned with no wrap, because the count is bounded by REQ-018.

Reset
REQ-033 rstn low SHALL asynchronously force: state = IDLE, o_ready = 0, o_ena = 0, o_wea = 0, o_addra = 0, o_dia = 0, o_start = 0, o_done = 0, o_err = 0, o_busy = 0, and all counters = 0.
REQ-034 Reset mid-load SHALL discard the load; nothing SHALL resume after reset deasserts.

Structure
REQ-035 DW, AW, NB and the FSM state encoding SHALL live in the shared parsing package.
REQ-036 The block SHALL be a single module; no sub-module is required.
REQ-037 o_ena/o_wea/o_addra/o_dia SHALL connect directly to the bank-array write ports; o_start SHALL connect to the parser's iStart.

Verification
REQ-038 Scenario: num_words = 32, continuous valid, data = index -> bank b receives data b at addr 0 and 16+b at addr 1; o_start fires 2 cycles after the 32nd accept.
REQ-039 Scenario: num_words = 8192, random valid gaps -> every bank addr 0..511 is written once with the correct beat; exactly one o_done.
REQ-040 Scenario: num_words = 17 -> bank 0 is written at addr 0 and addr 1, banks 1..15 only at addr 0; the final write is bank 0, addr 1.
REQ-041 Scenario: num_words = 0, then 9000 -> o_err pulses twice; o_busy stays 0; no writes occur.
REQ-042 Scenario: i_abort after 5 accepts of 20 -> exactly 5 writes occur, no o_start, state IDLE; a new 20-word load then completes normally.
REQ-043 Scenario: rstn low after 10 accepts -> all outputs 0 immediately; no write after rstn is released.
